// File: rtl/life_color_pkg.sv
// ============================================================================
// Module  : life_color_pkg
// Brief   : Shared GRB palette, dim shift, FSM state type and default age width
// Revision: 1.0
// ============================================================================
`default_nettype none

package life_color_pkg;

  localparam logic [23:0] OFF    = 24'h000000;
  localparam logic [23:0] GREEN  = 24'hFF0000;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] RED    = 24'h00FF00;
  localparam logic [23:0] BLUE   = 24'h0000FF;

  localparam int DIM_SHIFT     = 2;
  localparam int AGE_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    UPDATE = 2'd2
  } state_e;

  function automatic logic [23:0] dim_grb(input logic [23:0] c);
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    g = c[23:16] >> DIM_SHIFT;
    r = c[15:8]  >> DIM_SHIFT;
    b = c[7:0]   >> DIM_SHIFT;
    return {g, r, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cell_age.sv
// ============================================================================
// Module  : cell_age
// Brief   : One cell's registered alive flag and saturating age counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module cell_age
  import life_color_pkg::*;
#(
  parameter int AGE_W = AGE_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             update_en,
  input  logic             alive_in,
  output logic             alive_q,
  output logic [AGE_W-1:0] age_q
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic             alive_d;
  logic [AGE_W-1:0] age_d;

  always_comb begin
    alive_d = alive_q;
    age_d   = age_q;
    if (update_en) begin
      alive_d = alive_in;
      // Only a survivor ages; births and deaths both restart at zero.
      if (alive_in && alive_q) begin
        age_d = (age_q == AGE_MAX) ? AGE_MAX : age_q + AGE_W'(1);
      end else begin
        age_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alive_q <= 1'b0;
      age_q   <= '0;
    end else begin
      alive_q <= alive_d;
      age_q   <= age_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cell_age_colorizer.sv
// ============================================================================
// Module  : cell_age_colorizer
// Brief   : Per-cell age tracking and registered GRB colour lookup by age.
//           Optional macro COLOR_DIM_EN quarters every palette channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cell_age_colorizer
  import life_color_pkg::*;
#(
  parameter int NUM_CELLS = 64,
  parameter int AGE_W     = AGE_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         step,
  input  logic [NUM_CELLS-1:0]         grid,
  input  logic                         pixel_req,
  input  logic [$clog2(NUM_CELLS)-1:0] pixel_idx,
  output logic                         pixel_valid,
  output logic [23:0]                  pixel_color,
  output logic                         busy,
  output logic                         step_overrun
);

  localparam int IDX_W     = $clog2(NUM_CELLS);
  localparam int NUM_SLOTS = 2 ** IDX_W;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_e      state_q;
  state_e      state_d;
  logic        step_overrun_q;
  logic        step_overrun_d;
  logic        pixel_valid_q;
  logic        pixel_valid_d;
  logic [23:0] pixel_color_q;
  logic [23:0] pixel_color_d;
  logic        update_en;
  logic [23:0] lookup_color;

  // Slots beyond NUM_CELLS read as dead, so out-of-range indices return OFF.
  logic [NUM_SLOTS-1:0] alive_slot;
  logic [AGE_W-1:0]     age_slot [NUM_SLOTS];

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    cell_age #(
      .AGE_W(AGE_W)
    ) u_cell (
      .clk      (clk),
      .reset_n  (reset_n),
      .update_en(update_en),
      .alive_in (grid[i]),
      .alive_q  (alive_slot[i]),
      .age_q    (age_slot[i])
    );
  end

  if (NUM_SLOTS > NUM_CELLS) begin : g_pad
    for (genvar j = NUM_CELLS; j < NUM_SLOTS; j++) begin : g_pad_slot
      assign alive_slot[j] = 1'b0;
      assign age_slot[j]   = '0;
    end
  end

  function automatic logic [23:0] palette(input logic alive, input logic [AGE_W-1:0] age);
    logic [23:0] c;
    if (!alive)                 c = OFF;
    else if (age == '0)         c = GREEN;
    else if (age == AGE_MAX)    c = BLUE;
    else if (age == AGE_W'(1))  c = YELLOW;
    else                        c = RED;
`ifdef COLOR_DIM_EN
    return dim_grb(c);
`else
    return c;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      step_overrun_q <= 1'b0;
      pixel_valid_q  <= 1'b0;
      pixel_color_q  <= OFF;
    end else begin
      state_q        <= state_d;
      step_overrun_q <= step_overrun_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_color_q  <= pixel_color_d;
    end
  end

  // WAIT gives the rules engine one edge to register the new grid.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (step) state_d = WAIT;
      WAIT:    state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    update_en = (state_q == UPDATE);
  end

  assign lookup_color = palette(alive_slot[pixel_idx], age_slot[pixel_idx]);

  always_comb begin
    step_overrun_d = step_overrun_q | (step & busy);
    pixel_valid_d  = pixel_req;
    pixel_color_d  = pixel_req ? lookup_color : pixel_color_q;
  end

  assign pixel_valid  = pixel_valid_q;
  assign pixel_color  = pixel_color_q;
  assign step_overrun = step_overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_cell_age_colorizer.sv
// ============================================================================
// Module  : tb_cell_age_colorizer
// Brief   : Directed bench for cell_age_colorizer with a run-length age model.
//           Honours COLOR_DIM_EN for the expected palette.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cell_age_colorizer;

`ifdef COLOR_DIM_EN
  localparam logic [23:0] L_GREEN  = 24'h3F0000;
  localparam logic [23:0] L_YELLOW = 24'h3F3F00;
  localparam logic [23:0] L_RED    = 24'h003F00;
  localparam logic [23:0] L_BLUE   = 24'h00003F;
`else
  localparam logic [23:0] L_GREEN  = 24'hFF0000;
  localparam logic [23:0] L_YELLOW = 24'hFFFF00;
  localparam logic [23:0] L_RED    = 24'h00FF00;
  localparam logic [23:0] L_BLUE   = 24'h0000FF;
`endif
  localparam logic [23:0] L_OFF = 24'h000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step = 1'b0;
  logic [63:0] grid = '0;
  logic        pixel_req = 1'b0;
  logic [5:0]  pixel_idx = '0;
  logic        pixel_valid;
  logic [23:0] pixel_color;
  logic        busy;
  logic        step_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  cell_age_colorizer #(.NUM_CELLS(64), .AGE_W(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .step        (step),
    .grid        (grid),
    .pixel_req   (pixel_req),
    .pixel_idx   (pixel_idx),
    .pixel_valid (pixel_valid),
    .pixel_color (pixel_color),
    .busy        (busy),
    .step_overrun(step_overrun)
  );

  always #5 clk = ~clk;

  // Model: a cell's age is (consecutive steps alive - 1) clamped at 7.
  int          run [64] = '{default: 0};
  int          busy_left = 0;
  bit          m_ovr = 1'b0;
  bit          exp_v = 1'b0;
  logic [23:0] exp_c = '0;

  function automatic logic [23:0] model_color(input int r);
    int a;
    if (r == 0) return L_OFF;
    a = (r - 1 > 7) ? 7 : r - 1;
    if (a == 0) return L_GREEN;
    if (a == 1) return L_YELLOW;
    if (a == 7) return L_BLUE;
    return L_RED;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) run[i] = 0;
      busy_left = 0;
      m_ovr     = 1'b0;
      exp_v     = 1'b0;
      exp_c     = '0;
    end else begin
      exp_v = pixel_req;
      if (pixel_req) exp_c = model_color(run[pixel_idx]);
      if (step && busy_left != 0) m_ovr = 1'b1;
      if (busy_left == 1) begin
        for (int i = 0; i < 64; i++) run[i] = grid[i] ? run[i] + 1 : 0;
      end
      if (busy_left != 0) busy_left = busy_left - 1;
      else if (step)      busy_left = 2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("valid", 32'(pixel_valid), 32'(exp_v));
    check("color", 32'(pixel_color), 32'(exp_c));
    check("busy", 32'(busy), 32'(busy_left != 0));
    check("overrun", 32'(step_overrun), 32'(m_ovr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_lit(input int idx, input logic [23:0] lit, input string name);
    pixel_idx = 6'(idx);
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    check({name, "_valid"}, 32'(pixel_valid), 32'd1);
    check(name, 32'(pixel_color), 32'(lit));
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
  endtask

  logic [23:0] age_tab [8];

  initial begin
    age_tab = '{L_YELLOW, L_RED, L_RED, L_RED, L_RED, L_RED, L_BLUE, L_BLUE};

    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(step_overrun), 32'd0);
    check("rst_color", 32'(pixel_color), 32'd0);
    req_lit(5, L_OFF, "idle_idx5");
    tick();
    check("valid_one_cycle", 32'(pixel_valid), 32'd0);
    check("color_hold", 32'(pixel_color), 32'd0);

    grid = 64'h4020E00000000000;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("busy_wait", 32'(busy), 32'd1);
    tick();
    check("busy_update", 32'(busy), 32'd1);
    tick();
    check("busy_done", 32'(busy), 32'd0);
    req_lit(46, L_GREEN, "birth46");
    req_lit(0, L_OFF, "dead0");

    grid = 64'(1) << 46;
    for (int s = 0; s < 8; s++) begin
      do_step();
      req_lit(46, age_tab[s], "age46");
    end
    pixel_idx = 6'd45; pixel_req = 1'b1; tick();
    pixel_idx = 6'd46; tick();
    pixel_idx = 6'd47; tick();
    pixel_req = 1'b0;
    check("b2b_last", 32'(pixel_color), 32'd0);
    tick();

    grid = '0;
    do_step();
    req_lit(46, L_OFF, "died46");
    grid = 64'(1) << 46;
    do_step();
    req_lit(46, L_GREEN, "reborn46");

    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    pixel_idx = 6'd46;
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    check("req_in_update", 32'(pixel_color), 32'(L_GREEN));
    check("ovr_set", 32'(step_overrun), 32'd1);
    tick(); tick();
    req_lit(46, L_YELLOW, "one_step_only");
    check("ovr_sticky", 32'(step_overrun), 32'd1);

    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(pixel_valid), 32'd0);
    check("mid_rst_color", 32'(pixel_color), 32'd0);
    check("mid_rst_ovr", 32'(step_overrun), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    do_step();
    req_lit(46, L_GREEN, "post_rst_birth");
    req_lit(45, L_OFF, "post_rst_dead");
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
